// File: rtl/gpio_pkg.sv
// gpio_pkg: shared constants and helpers for the memory-mapped GPIO block.
//   - Bus byte addresses of the GPIO registers (output side at 1024, input side 1028-1040).
//   - Width of the per-bit debounce counter.
//   - gpio_reg_e / gpio_decode: exact 32-bit address match to an input-side register select.
package gpio_pkg;

  localparam logic [31:0] GPIO_OUT_ADDR  = 32'd1024;
  localparam logic [31:0] GPIO_LVL_ADDR  = 32'd1028;
  localparam logic [31:0] GPIO_EDGE_ADDR = 32'd1032;
  localparam logic [31:0] GPIO_IEN_ADDR  = 32'd1036;
  localparam logic [31:0] GPIO_ESEL_ADDR = 32'd1040;

  localparam int DB_CNT_W = 8;

  typedef enum logic [2:0] {
    RegNone,
    RegLvl,
    RegEdge,
    RegIen,
    RegEsel
  } gpio_reg_e;

  // Anything that is not an exact match (including the output register) decodes to RegNone.
  function automatic gpio_reg_e gpio_decode(input logic [31:0] a);
    gpio_reg_e r;
    case (a)
      GPIO_LVL_ADDR:  r = RegLvl;
      GPIO_EDGE_ADDR: r = RegEdge;
      GPIO_IEN_ADDR:  r = RegIen;
      GPIO_ESEL_ADDR: r = RegEsel;
      default:        r = RegNone;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one input pin -> 2-flop synchroniser -> debounce counter -> level register.
//   A new synchronised level is accepted once it has differed from the current level for
//   DB_CYCLES consecutive cycles; any sample equal to the current level restarts the count.
//   Latency from pin change to level update is 2 + DB_CYCLES clock cycles.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset (clears synchroniser, counter and level)
//   pin_i   in   asynchronous external pin
//   lvl_o   out  debounced level (registered)
//   rise_o  out  high in the cycle whose clock edge moves lvl_o 0->1
//   fall_o  out  high in the cycle whose clock edge moves lvl_o 1->0
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [DB_CNT_W-1:0] CntMax = DB_CNT_W'(DB_CYCLES - 1);

  logic [1:0]          sync_q;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                lvl_q, lvl_d;
  logic                sync_val;
  logic                accept;

  assign sync_val = sync_q[1];

  always_comb begin
    accept = (sync_val != lvl_q) && (cnt_q == CntMax);
    cnt_d  = cnt_q;
    lvl_d  = lvl_q;
    if (sync_val == lvl_q) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = '0;
      lvl_d = sync_val;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl_o = lvl_q;
  // Pulses are combinational so the edge register can update on the same edge as the level.
  assign rise_o = accept & sync_val;
  assign fall_o = accept & ~sync_val;

endmodule

// File: rtl/gpio_in_reader.sv
// gpio_in_reader: read side of the memory-mapped GPIO block.
//   Debounces WIDTH input pins, captures selected edges into sticky status bits and raises a
//   maskable level interrupt. Registers (exact 32-bit byte address match):
//     1028 LVL       RO   debounced levels
//     1032 EDGE      W1C  sticky edge status; a new edge wins over a same-cycle clear
//     1036 IRQ_EN    RW   per-bit interrupt enable
//     1040 EDGE_SEL  RW   0 = rising edge, 1 = falling edge
//   Unmapped reads return 0 with rd_valid; bits above WIDTH read as 0.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   write_sinal  in   bus write strobe, qualified by addr
//   read_sinal   in   bus read strobe, qualified by addr
//   addr         in   bus byte address
//   in_data      in   bus write data
//   gpio_in      in   asynchronous external pins
//   rd_data      out  read data, registered, valid with rd_valid
//   rd_valid     out  one-cycle pulse the cycle after read_sinal
//   irq          out  registered |(EDGE & IRQ_EN)
module gpio_in_reader
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             write_sinal,
  input  logic             read_sinal,
  input  logic [31:0]      addr,
  input  logic [31:0]      in_data,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             irq
);

  logic [WIDTH-1:0] lvl, rise, fall;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] esel_q, esel_d;
  logic [WIDTH-1:0] edge_set, edge_clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      rd_mux;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q;
  logic             irq_q, irq_d;
  gpio_reg_e        wr_reg, rd_reg;
  logic             unused_in_data;

  // Per-pin input path.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .pin_i (gpio_in[i]),
      .lvl_o (lvl[i]),
      .rise_o(rise[i]),
      .fall_o(fall[i])
    );
  end

  assign wdata          = in_data[WIDTH-1:0];
  assign unused_in_data = ^in_data;

  always_comb begin
    wr_reg = write_sinal ? gpio_decode(addr) : RegNone;
    rd_reg = read_sinal ? gpio_decode(addr) : RegNone;

    // EDGE_SEL is sampled as it stands before this edge, so changing it never fakes an edge.
    edge_set = (rise & ~esel_q) | (fall & esel_q);
    edge_clr = (wr_reg == RegEdge) ? wdata : '0;
    edge_d   = (edge_q & ~edge_clr) | edge_set;

    ien_d  = (wr_reg == RegIen) ? wdata : ien_q;
    esel_d = (wr_reg == RegEsel) ? wdata : esel_q;

    // Reads see the register values before any same-cycle update.
    case (rd_reg)
      RegLvl:  rd_mux = 32'(lvl);
      RegEdge: rd_mux = 32'(edge_q);
      RegIen:  rd_mux = 32'(ien_q);
      RegEsel: rd_mux = 32'(esel_q);
      default: rd_mux = '0;
    endcase
    rd_data_d = read_sinal ? rd_mux : rd_data_q;

    irq_d = |(edge_q & ien_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q     <= '0;
      ien_q      <= '0;
      esel_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      edge_q     <= edge_d;
      ien_q      <= ien_d;
      esel_q     <= esel_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= read_sinal;
      irq_q      <= irq_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_in_reader.sv
// tb_gpio_in_reader: directed scenarios plus randomized pins and bus traffic, all checked
// against a reference model that decides level changes from the recent pin history.
module tb_gpio_in_reader;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_sinal = 1'b0;
  logic        read_sinal = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] in_data = '0;
  logic [15:0] gpio_in = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  gpio_in_reader #(
    .WIDTH    (16),
    .DB_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .write_sinal(write_sinal),
    .read_sinal (read_sinal),
    .addr       (addr),
    .in_data    (in_data),
    .gpio_in    (gpio_in),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model state
  logic [15:0] m_lvl, m_edge, m_ien, m_esel;
  logic [31:0] m_rd;
  logic [15:0] hist[$];  // pin value seen at each clock edge since reset

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] regval(input logic [31:0] a);
    case (a)
      32'd1028: return {16'h0, m_lvl};
      32'd1032: return {16'h0, m_edge};
      32'd1036: return {16'h0, m_ien};
      32'd1040: return {16'h0, m_esel};
      default:  return 32'h0;
    endcase
  endfunction

  // One clock edge: predict from the inputs currently applied, then compare after the edge.
  task automatic tick();
    logic [15:0] upd, nl, setm, w1c;
    logic        all_diff, exp_v, exp_irq;
    int          n;
    hist.push_back(gpio_in);
    if (hist.size() > 32) void'(hist.pop_front());
    n = hist.size();
    // The synchronised sample used at this edge is the pin value from two edges back; a level
    // flips once the last DB such samples all disagree with it.
    upd = '0;
    for (int i = 0; i < 16; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) if (hist[n - 3 - j][i] == m_lvl[i]) all_diff = 1'b0;
      upd[i] = all_diff;
    end
    nl      = m_lvl ^ upd;
    setm    = (upd & nl & ~m_esel) | (upd & ~nl & m_esel);
    exp_irq = |(m_edge & m_ien);
    exp_v   = read_sinal;
    if (read_sinal) m_rd = regval(addr);
    w1c = (write_sinal && addr == 32'd1032) ? in_data[15:0] : 16'h0;
    m_edge = (m_edge & ~w1c) | setm;
    if (write_sinal && addr == 32'd1036) m_ien = in_data[15:0];
    if (write_sinal && addr == 32'd1040) m_esel = in_data[15:0];
    m_lvl = nl;
    @(posedge clk);
    #1;
    check_eq("rd_valid", {31'h0, rd_valid}, {31'h0, exp_v});
    check_eq("irq", {31'h0, irq}, {31'h0, exp_irq});
    if (exp_v) check_eq("rd_data", rd_data, m_rd);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) tick();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    write_sinal = 1'b1;
    addr        = a;
    in_data     = d;
    tick();
    write_sinal = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    read_sinal = 1'b1;
    addr       = a;
    tick();
    read_sinal = 1'b0;
    d          = rd_data;
  endtask

  task automatic do_reset();
    write_sinal = 1'b0;
    read_sinal  = 1'b0;
    rst_n       = 1'b0;
    #1;
    check_eq("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_eq("rst_rd_data", rd_data, 32'h0);
    m_lvl  = '0;
    m_edge = '0;
    m_ien  = '0;
    m_esel = '0;
    m_rd   = '0;
    hist.delete();
    repeat (DB + 2) hist.push_back(16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] rd;
  logic [31:0] addr_tab[7];

  initial begin
    addr_tab = '{32'd1024, 32'd1028, 32'd1032, 32'd1036, 32'd1040, 32'd1044, 32'd2000};

    // Reset with all pins high: levels rise 2+DB cycles after release, rising edges captured.
    gpio_in = 16'hFFFF;
    do_reset();
    idle(5);
    bus_rd(32'd1028, rd);
    check_eq("lvl_before_accept", rd, 32'h0);
    bus_rd(32'd1028, rd);
    check_eq("lvl_after_reset", rd, 32'h0000_FFFF);
    bus_rd(32'd1032, rd);
    check_eq("edge_after_reset", rd, 32'h0000_FFFF);
    bus_wr(32'd1032, 32'hFFFF_FFFF);
    gpio_in = 16'h0;
    idle(10);
    bus_wr(32'd1036, 32'h8);

    // Short glitch on pin 3 is filtered.
    gpio_in = 16'h0008;
    idle(3);
    gpio_in = 16'h0;
    idle(10);
    bus_rd(32'd1028, rd);
    check_eq("glitch_lvl", rd, 32'h0);

    // Held pin 3 accepted exactly 2+DB cycles later; edge and irq follow.
    gpio_in = 16'h0008;
    idle(5);
    bus_rd(32'd1028, rd);
    check_eq("hold_lvl_early", rd, 32'h0);
    bus_rd(32'd1028, rd);
    check_eq("hold_lvl", rd, 32'h8);
    check_eq("irq_set", {31'h0, irq}, 32'h1);
    bus_rd(32'd1032, rd);
    check_eq("edge3", rd, 32'h8);
    bus_wr(32'd1032, 32'h8);
    check_eq("irq_still", {31'h0, irq}, 32'h1);
    idle(1);
    check_eq("irq_clear", {31'h0, irq}, 32'h0);

    // Falling-edge select on pin 0.
    bus_wr(32'd1040, 32'h1);
    gpio_in = 16'h0009;
    idle(10);
    bus_rd(32'd1032, rd);
    check_eq("fall_no_rise", rd, 32'h0);
    gpio_in = 16'h0008;
    idle(10);
    bus_rd(32'd1032, rd);
    check_eq("fall_edge", rd, 32'h1);
    bus_wr(32'd1032, 32'h1);
    bus_wr(32'd1040, 32'h0);

    // W1C in the same cycle as a new rise on bit 3: set wins.
    gpio_in = 16'h0;
    idle(10);
    gpio_in = 16'h0008;
    idle(5);
    bus_wr(32'd1032, 32'h8);
    bus_rd(32'd1032, rd);
    check_eq("collision", rd, 32'h8);

    // Back-to-back reads, the last unmapped.
    read_sinal = 1'b1;
    for (int k = 1; k < 5; k++) begin
      addr = addr_tab[k];
      tick();
    end
    addr = 32'd2000;
    tick();
    read_sinal = 1'b0;
    check_eq("b2b_last_valid", {31'h0, rd_valid}, 32'h1);
    check_eq("b2b_last_data", rd_data, 32'h0);
    bus_wr(32'd1028, 32'hFFFF_FFFF);
    bus_rd(32'd1028, rd);
    check_eq("lvl_ro", rd, 32'h8);

    // Async reset right after a read.
    read_sinal = 1'b1;
    addr       = 32'd1028;
    tick();
    do_reset();

    // Randomized pins and bus traffic.
    for (int it = 0; it < 3000; it++) begin
      if (it == 1500) do_reset();
      if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 16'(32'd1 << $urandom_range(0, 15));
      write_sinal = 1'b0;
      read_sinal  = 1'b0;
      addr        = addr_tab[$urandom_range(0, 6)];
      in_data     = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: read_sinal = 1'b1;
        4:          write_sinal = 1'b1;
        5: begin
          read_sinal  = 1'b1;
          write_sinal = 1'b1;
        end
        default: ;
      endcase
      tick();
    end
    write_sinal = 1'b0;
    read_sinal  = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
